// File: rtl/pipe_ctrl_unit.sv
// Pipeline control sequencer: turns hazard-unit stall/flush requests into
// per-stage enables, clears and bubbles, and counts stall and flush activity.
module pipe_ctrl_unit #(
    parameter int LD2_CYC = 2,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_ld_2clk_i,
    input  logic             stall_ld_1clk_i,
    input  logic             flush_d_i,
    input  logic             flush_f_i,
    input  logic             ext_stall_i,
    output logic             en_f_o,
    output logic             en_d_o,
    output logic             clr_d_o,
    output logic             clr_e_o,
    output logic             en_back_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_e;

    localparam logic [3:0] REM_INIT = 4'(LD2_CYC - 1);

    state_e            state_q, state_d;
    logic [3:0]        rem_q, rem_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              frz, ldst;

    assign frz  = ext_stall_i;
    // A decode flush kills the dependent instruction, so it cancels any stall.
    assign ldst = !frz && !flush_d_i &&
                  (((state_q == RUN) && (stall_ld_2clk_i || stall_ld_1clk_i)) ||
                   (state_q == STALL));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            rem_q       <= 4'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!frz) begin
            unique case (state_q)
                RUN: begin
                    if (!flush_d_i && stall_ld_2clk_i) begin
                        state_d = STALL;
                        rem_d   = REM_INIT;
                    end
                end
                STALL: begin
                    if (flush_d_i || rem_q == 4'd1) begin
                        state_d = RUN;
                        rem_d   = 4'd0;
                    end else begin
                        rem_d = rem_q - 4'd1;
                    end
                end
                default: begin
                    state_d = RUN;
                    rem_d   = 4'd0;
                end
            endcase
            if (ldst)
                stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (flush_d_i || flush_f_i)
                flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Controls are forced low while reset is asserted, independent of inputs.
    always_comb begin
        en_f_o    = 1'b0;
        en_d_o    = 1'b0;
        clr_d_o   = 1'b0;
        clr_e_o   = 1'b0;
        en_back_o = 1'b0;
        busy_o    = 1'b0;
        if (rst_n) begin
            en_f_o    = !frz && (!ldst || flush_f_i);
            en_d_o    = !frz && !ldst;
            clr_d_o   = !frz && flush_f_i && !ldst;
            clr_e_o   = !frz && (ldst || flush_d_i);
            en_back_o = !frz;
            busy_o    = (state_q == STALL);
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: two instances (load stall of 2 and 4 cycles) driven
// by shared directed + random stimulus, compared against a cycle-level model.
module tb_pipe_ctrl_unit;

    logic clk = 1'b0;
    logic rst_n;
    logic s2, s1, fd, ff, ext;

    logic        en_f[2], en_d[2], clr_d[2], clr_e[2], en_back[2], busy[2];
    logic [31:0] sc[2], fc[2];

    int n_chk  = 0;
    int n_fail = 0;

    int          LD[2] = '{2, 4};
    int          m_left[2];
    logic [31:0] m_sc[2], m_fc[2];

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.LD2_CYC(2), .CNT_W(32)) u_ld2 (
        .clk(clk), .rst_n(rst_n),
        .stall_ld_2clk_i(s2), .stall_ld_1clk_i(s1),
        .flush_d_i(fd), .flush_f_i(ff), .ext_stall_i(ext),
        .en_f_o(en_f[0]), .en_d_o(en_d[0]), .clr_d_o(clr_d[0]), .clr_e_o(clr_e[0]),
        .en_back_o(en_back[0]), .busy_o(busy[0]),
        .stall_cnt_o(sc[0]), .flush_cnt_o(fc[0])
    );

    pipe_ctrl_unit #(.LD2_CYC(4), .CNT_W(32)) u_ld4 (
        .clk(clk), .rst_n(rst_n),
        .stall_ld_2clk_i(s2), .stall_ld_1clk_i(s1),
        .flush_d_i(fd), .flush_f_i(ff), .ext_stall_i(ext),
        .en_f_o(en_f[1]), .en_d_o(en_d[1]), .clr_d_o(clr_d[1]), .clr_e_o(clr_e[1]),
        .en_back_o(en_back[1]), .busy_o(busy[1]),
        .stall_cnt_o(sc[1]), .flush_cnt_o(fc[1])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_left[i] = 0;
            m_sc[i]   = '0;
            m_fc[i]   = '0;
        end
    endtask

    // Model: m_left = stall cycles still owed after the current one.
    function automatic logic m_ldst(input int i);
        return !ext && !fd && (m_left[i] > 0 || s2 || s1);
    endfunction

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            logic l;
            string p;
            l = m_ldst(i);
            p = $sformatf("ld%0d", LD[i]);
            chk({p, " en_f"},    en_f[i],    !ext && (!l || ff));
            chk({p, " en_d"},    en_d[i],    !ext && !l);
            chk({p, " clr_d"},   clr_d[i],   !ext && ff && !l);
            chk({p, " clr_e"},   clr_e[i],   !ext && (l || fd));
            chk({p, " en_back"}, en_back[i], !ext);
            chk({p, " busy"},    busy[i],    m_left[i] > 0);
            chk({p, " stall_cnt"}, sc[i], m_sc[i]);
            chk({p, " flush_cnt"}, fc[i], m_fc[i]);
        end
    endtask

    task automatic check_reset_zero();
        for (int i = 0; i < 2; i++) begin
            chk("rst en_f", en_f[i], 0);
            chk("rst en_d", en_d[i], 0);
            chk("rst clr_d", clr_d[i], 0);
            chk("rst clr_e", clr_e[i], 0);
            chk("rst en_back", en_back[i], 0);
            chk("rst busy", busy[i], 0);
            chk("rst stall_cnt", sc[i], 0);
            chk("rst flush_cnt", fc[i], 0);
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            logic l;
            l = m_ldst(i);
            if (!ext) begin
                if (l) m_sc[i] = m_sc[i] + 1;
                if (fd || ff) m_fc[i] = m_fc[i] + 1;
                if (m_left[i] > 0) m_left[i] = fd ? 0 : m_left[i] - 1;
                else if (!fd && s2) m_left[i] = LD[i] - 1;
            end
        end
    endtask

    task automatic cyc(input logic a2, input logic a1, input logic ad,
                       input logic af, input logic ae);
        s2 = a2; s1 = a1; fd = ad; ff = af; ext = ae;
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        {s2, s1, fd, ff, ext} = 5'b0;
        model_reset();
        @(posedge clk);
        #2 check_reset_zero();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        // idle, then single-cycle load-2 hazard
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        // load-1 hazard alone
        cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        // decode flush in the second stall cycle
        cyc(1, 0, 0, 0, 0); cyc(0, 0, 1, 0, 0); cyc(0, 0, 0, 0, 0);
        // flush_d and load-2 together in RUN
        cyc(1, 0, 1, 0, 0); cyc(0, 0, 0, 0, 0);
        // fetch redirect during stall, then in RUN
        cyc(1, 0, 0, 0, 0); cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 1, 0);
        // freeze while the long stall has one cycle left
        cyc(1, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 1); cyc(0, 0, 1, 1, 1); cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        // random traffic
        for (int n = 0; n < 3000; n++)
            cyc($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 7) == 0);
        // reset in the middle of a stall, hazards still asserted
        cyc(1, 0, 0, 0, 0);
        s2 = 1'b1; s1 = 1'b1; ff = 1'b1;
        rst_n = 1'b0;
        #2 check_reset_zero();
        model_reset();
        @(negedge clk) check_reset_zero();
        @(posedge clk);
        #1;
        {s2, s1, fd, ff, ext} = 5'b0;
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
Pipeline control sequencer directly downstream of the hazard unit. It consumes the load-use stall requests and the decode/fetch flush requests. It turns them into per-stage register enables, clears and bubble inserts for the 5-stage RISC-V pipeline. A small FSM enforces the full multi-cycle load-use stall, and the block keeps stall and flush performance counters.

Parameters:
LD2_CYC, 2, total stall cycles for a load in execute feeding decode (range 2..15)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall_ld_2clk_i  in  1  load in EX, dependent instruction in decode
stall_ld_1clk_i  in  1  load in MEM, dependent instruction in decode
flush_d_i  in  1  kill instruction in decode
flush_f_i  in  1  redirect fetch (kill the fetch-stage instruction)
ext_stall_i  in  1  global freeze (data memory wait)
en_f_o  out  1  PC register enable
en_d_o  out  1  F/D register enable
clr_d_o  out  1  F/D synchronous clear
clr_e_o  out  1  D/E synchronous clear (bubble insert)
en_back_o  out  1  E/M and M/W register enable
busy_o  out  1  FSM in STALL state
stall_cnt_o  out  CNT_W  load-use stall cycles counted
flush_cnt_o  out  CNT_W  flush events counted

Behaviour:
- Reset is asynchronous and active-low.
  - While rst_n=0: state=RUN, rem=0, both counters 0.
  - While rst_n=0: all en_*/clr_* outputs are 0 and busy_o=0.
- State is RUN or STALL. rem is a 4-bit count of remaining STALL cycles.
- Outputs are combinational from state and inputs, with zero-cycle latency.
- Internal terms:
  - frz = ext_stall_i.
  - ldst = !frz && !flush_d_i && ((RUN && (stall_ld_2clk_i || stall_ld_1clk_i)) || STALL).
- Output equations:
  - en_f_o = !frz && (!ldst || flush_f_i). A redirect always updates the PC, even during a stall.
  - en_d_o = !frz && !ldst.
  - clr_d_o = !frz && flush_f_i && !ldst. A held F/D contains the stalled decode instruction and is never cleared by flush_f.
  - clr_e_o = !frz && (ldst || flush_d_i).
  - en_back_o = !frz.
  - busy_o = (state==STALL).
- FSM transitions, when frz=0:
  - RUN, flush_d_i=1: stay RUN. The stall is cancelled because the dependent instruction is killed.
  - RUN, stall_ld_2clk_i=1: go to STALL with rem=LD2_CYC-1.
  - RUN, only stall_ld_1clk_i=1: stay RUN. The stall lasts a single cycle.
  - STALL, flush_d_i=1: go to RUN with rem=0 (abort).
  - STALL, rem==1: go to RUN.
  - STALL, otherwise: rem decrements by 1.
  - Hazard inputs are ignored while in STALL. The FSM alone sets the stall length.
- With frz=1: state, rem and counters hold, and all enables and clears are 0. Upstream holds the flush inputs stable while frozen, so no event is lost.
- Counters, both wrapping modulo 2^CNT_W:
  - stall_cnt increments by 1 in every cycle where ldst=1.
  - flush_cnt increments by 1 per cycle in which flush_d_i or flush_f_i is 1 and frz=0.
  - Simultaneous flush_d_i and flush_f_i count once.
- Simultaneous flush_d_i and stall_ld_2clk_i in RUN: the flush wins. The result is clr_e_o=1, en_d_o=1, and no STALL entry.

Test Plan:
- Reset then idle: rst_n low mid-operation (state STALL) -> outputs 0 immediately. After release: en_f=en_d=en_back=1, clr_*=0, busy=0, counters 0.
- stall_ld_2clk_i pulse for 1 cycle, LD2_CYC=2 -> cycle0 en_f=en_d=0, clr_e=1. Cycle1 busy=1 with the same outputs. Cycle2 back to RUN. stall_cnt=2.
- stall_ld_1clk_i alone for 1 cycle -> exactly 1 stall cycle with clr_e=1 and no busy. stall_cnt=1.
- flush_d_i asserted in the 2nd cycle of a LD2_CYC=4 stall -> that cycle en_d=1, clr_e=1. Next cycle RUN. stall_cnt=1, flush_cnt=1.
- flush_f_i during STALL -> en_f=1, clr_d=0, en_d=0. With flush_f_i in RUN and no hazard -> clr_d=1.
- ext_stall_i held 3 cycles during STALL (rem=1) -> all enables and clears 0 and counters frozen. On release, the STALL cycle completes and the FSM returns to RUN.
